// File: rtl/fetch_if.sv
// Fetch unit bus bundle: shared memory port (request/grant/read data),
// instruction hand-off to execute (inst/inst_pc/inst_valid/inst_ready)
// and the redirect request from execute.
//   master : fetch unit side
//   slave  : memory / execute side
interface fetch_if;
  localparam int unsigned PC_W   = 7;
  localparam int unsigned DATA_W = 16;

  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;

  modport master (
    output mem_req, mem_addr, inst, inst_pc, inst_valid,
    input  mem_gnt, mem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst, inst_pc, inst_valid,
    output mem_gnt, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a fetch pointer through word memory over a
// shared port, buffers {pc, word} in a DEPTH-entry FIFO and presents the
// head to execute. Redirect flushes the buffer and restarts fetch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_if.master (mem_req/mem_addr/mem_gnt/mem_rdata,
//                inst/inst_pc/inst_valid/inst_ready, redirect/redirect_pc)
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [6:0]  RESET_PC = 7'd0
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int unsigned PC_W   = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] word;
  } entry_t;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   fpc_q;
  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              req_c, push_c, pop_c, has_inst_c;

  // Pointer increment that wraps at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake decode; redirect suppresses the request.
  always_comb begin
    state_d    = state_q;
    has_inst_c = 1'b0;
    req_c      = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: state_d = FETCH;
      default: state_d = IDLE;
    endcase
    has_inst_c = (count_q != '0);
    req_c      = (state_q == FETCH) && (count_q < CNT_W'(DEPTH)) && !bus.redirect;
    push_c     = req_c && bus.mem_gnt;
    pop_c      = has_inst_c && bus.inst_ready;
  end

  // Fetch pointer and instruction buffer; redirect wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (bus.redirect) begin
      fpc_q    <= bus.redirect_pc;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= '{pc: fpc_q, word: bus.mem_rdata};
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        fpc_q            <= fpc_q + PC_W'(1);
      end
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_q <= count_q - CNT_W'(1);
    end
  end

  assign bus.mem_addr   = fpc_q;
  assign bus.mem_req    = req_c;
  assign bus.inst_valid = has_inst_c;
  assign bus.inst       = has_inst_c ? fifo_q[rd_ptr_q].word : '0;
  assign bus.inst_pc    = has_inst_c ? fifo_q[rd_ptr_q].pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [6:0]  RESET_PC = 7'd0;

  typedef struct packed {
    logic [6:0]  pc;
    logic [15:0] w;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] mem_words [128];

  int n_checks = 0;
  int n_pass   = 0;

  fetch_if bus ();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem_words[bus.mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a queue of fetched words and a fetch address.
  ent_t       mq[$];
  logic [6:0] mfpc     = RESET_PC;
  bit         mstarted = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mfpc     = RESET_PC;
      mstarted = 1'b0;
    end else begin
      bit req, push, pop;
      req  = mstarted && (mq.size() < int'(DEPTH)) && !bus.redirect;
      push = req && bus.mem_gnt;
      pop  = (mq.size() > 0) && bus.inst_ready;
      if (bus.redirect) begin
        mq.delete();
        mfpc = bus.redirect_pc;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back('{pc: mfpc, w: mem_words[mfpc]});
          mfpc = 7'((int'(mfpc) + 1) % 128);
        end
      end
      mstarted = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit         e_req, e_valid;
    logic [15:0] e_inst;
    logic [6:0]  e_pc;
    e_req   = rst_n && mstarted && (mq.size() < int'(DEPTH)) && !bus.redirect;
    e_valid = (mq.size() > 0);
    e_inst  = e_valid ? mq[0].w  : 16'h0000;
    e_pc    = e_valid ? mq[0].pc : 7'd0;
    chk("cyc_mem_req",    32'(bus.mem_req),    32'(e_req));
    chk("cyc_mem_addr",   32'(bus.mem_addr),   32'(mfpc));
    chk("cyc_inst_valid", 32'(bus.inst_valid), 32'(e_valid));
    chk("cyc_inst",       32'(bus.inst),       32'(e_inst));
    chk("cyc_inst_pc",    32'(bus.inst_pc),    32'(e_pc));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg_after(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_head(input string name, input logic [15:0] w, input logic [6:0] pc);
    chk({name, "_valid"}, 32'(bus.inst_valid), 32'd1);
    chk({name, "_inst"},  32'(bus.inst),       32'(w));
    chk({name, "_pc"},    32'(bus.inst_pc),    32'(pc));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.mem_gnt     = 1'b1;
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 7'd0;
    for (int i = 0; i < 128; i++) mem_words[i] = 16'($urandom);
    mem_words[0]   = 16'hF10A;
    mem_words[1]   = 16'hF202;
    mem_words[2]   = 16'h0312;
    mem_words[5]   = 16'h5555;
    mem_words[10]  = 16'hA55A;
    mem_words[127] = 16'h7F7F;

    // Reset state
    #2;
    chk("rst_req",   32'(bus.mem_req),    32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst",  32'(bus.inst),       32'd0);
    chk("rst_pc",    32'(bus.inst_pc),    32'd0);
    chk("rst_addr",  32'(bus.mem_addr),   32'(RESET_PC));

    // In-order streaming, first-instruction latency
    step(); rst_n = 1'b1;
    neg_after(1);
    chk("e0_req",   32'(bus.mem_req),    32'd1);
    chk("e0_valid", 32'(bus.inst_valid), 32'd0);
    neg_after(1); chk_head("str0", 16'hF10A, 7'd0);
    neg_after(1); chk_head("str1", 16'hF202, 7'd1);
    neg_after(1); chk_head("str2", 16'h0312, 7'd2);

    // Backpressure fills the buffer
    step(); rst_n = 1'b0; bus.inst_ready = 1'b0;
    step(); rst_n = 1'b1;
    neg_after(3);
    chk("bp_req",  32'(bus.mem_req),  32'd0);
    chk("bp_addr", 32'(bus.mem_addr), 32'd2);
    chk_head("bp_head", 16'hF10A, 7'd0);

    // Reset mid-stream clears outputs before any edge
    step(); rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.inst_valid), 32'd0);
    chk("mrst_req",   32'(bus.mem_req),    32'd0);
    chk("mrst_inst",  32'(bus.inst),       32'd0);
    step(); rst_n = 1'b1;
    neg_after(1); chk("mrst_e0_valid", 32'(bus.inst_valid), 32'd0);
    neg_after(1); chk_head("mrst_e1", 16'hF10A, 7'd0);
    neg_after(1);
    chk("full_req", 32'(bus.mem_req), 32'd0);

    // Drain after backpressure, no loss or duplication
    step(); bus.inst_ready = 1'b1;
    @(negedge clk); chk_head("drain0", 16'hF10A, 7'd0);
    neg_after(1);   chk_head("drain1", 16'hF202, 7'd1);
    neg_after(1);   chk_head("drain2", 16'h0312, 7'd2);

    // Grant stall with empty buffer
    step(); bus.redirect = 1'b1; bus.redirect_pc = 7'd10; bus.mem_gnt = 1'b0;
    step(); bus.redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req",   32'(bus.mem_req),    32'd1);
      chk("stall_addr",  32'(bus.mem_addr),   32'd10);
      chk("stall_valid", 32'(bus.inst_valid), 32'd0);
      @(posedge clk);
    end
    #1; bus.mem_gnt = 1'b1;
    @(negedge clk); chk("stall_end_valid", 32'(bus.inst_valid), 32'd0);
    neg_after(1);   chk_head("stall_word", 16'hA55A, 7'd10);

    // Redirect with a full buffer
    step(); bus.inst_ready = 1'b0;
    neg_after(3);
    chk("rdf_full_req", 32'(bus.mem_req), 32'd0);
    step(); bus.redirect = 1'b1; bus.redirect_pc = 7'd5;
    @(negedge clk); chk("rdf_req_low", 32'(bus.mem_req), 32'd0);
    step(); bus.redirect = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("rdf_valid", 32'(bus.inst_valid), 32'd0);
    chk("rdf_addr",  32'(bus.mem_addr),   32'd5);
    chk("rdf_req",   32'(bus.mem_req),    32'd1);
    neg_after(1); chk_head("rdf_word", 16'h5555, 7'd5);

    // Wrap-around at 127
    step(); bus.redirect = 1'b1; bus.redirect_pc = 7'd127;
    step(); bus.redirect = 1'b0;
    neg_after(1); chk_head("wrap127", 16'h7F7F, 7'd127);
    neg_after(1); chk_head("wrap0",   16'hF10A, 7'd0);
    neg_after(1); chk_head("wrap1",   16'hF202, 7'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst_n)                     rst_n = 1'b1;
      else if ($urandom_range(99) == 0) rst_n = 1'b0;
      bus.mem_gnt     = ($urandom_range(3) != 0);
      bus.inst_ready  = ($urandom_range(2) != 0);
      bus.redirect    = ($urandom_range(19) == 0);
      bus.redirect_pc = ($urandom_range(3) == 0) ? 7'(126 + $urandom_range(1)) : 7'($urandom);
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
Parameters:
REQ-001 SHALL have parameter DEPTH, default 2: instruction buffer entries (legal range 1..4).
REQ-002 SHALL have parameter RESET_PC, default 7'd0: fetch word address loaded at reset.
Ports:
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have mem_req  output  1  fetch request to the shared memory port.
REQ-006 SHALL have mem_addr  output  7  word address of the requested instruction.
REQ-007 SHALL have mem_gnt  input  1  port granted to fetch this cycle (data access has priority).
REQ-008 SHALL have mem_rdata  input  16  combinational read data for mem_addr, valid in a granted cycle.
REQ-009 SHALL have inst  output  16  instruction at buffer head.
REQ-010 SHALL have inst_pc  output  7  word address of inst.
REQ-011 SHALL have inst_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have inst_ready  input  1  execute stage accepts inst this cycle.
REQ-013 SHALL have redirect  input  1  flush and restart fetch at redirect_pc.
REQ-014 SHALL have redirect_pc  input  7  new fetch word address.

Function
REQ-015 SHALL implement states IDLE and FETCH: IDLE is held only during reset and moves to FETCH on the first rising edge with rst_n high; FETCH persists until reset.
REQ-016 SHALL hold a fetch pointer fpc (7 bits) and a FIFO of DEPTH entries of {pc[6:0], word[15:0]} with an occupancy count.
REQ-017 SHALL drive mem_addr = fpc at all times.
REQ-018 SHALL drive mem_req = 1 only when state is FETCH, count < DEPTH, and redirect is 0.
REQ-019 SHALL push {fpc, mem_rdata} and advance fpc by 1 modulo 128 (127 -> 0) on a rising edge where mem_req and mem_gnt are both 1.
REQ-020 SHALL leave fpc and the FIFO unchanged on a cycle with mem_req=1 and mem_gnt=0 (the request simply repeats).
REQ-021 SHALL drive inst_valid = (count != 0), with inst and inst_pc taken from the head entry, and drive inst = 16'h0000 and inst_pc = 7'd0 when the FIFO is empty.
REQ-022 SHALL pop the head on a rising edge where inst_valid and inst_ready are both 1.
REQ-023 SHALL handle push and pop on the same edge with count unchanged and program order preserved.
REQ-024 SHALL never push when count == DEPTH, since mem_req is low; a pop from full re-enables mem_req on the following cycle.
REQ-025 SHALL give redirect priority over all other events: on a rising edge with redirect=1, the FIFO is emptied, fpc <= redirect_pc, and any concurrent grant or pop is discarded.
REQ-026 SHALL issue the first request at redirect_pc in the cycle after redirect, provided redirect has dropped.
REQ-027 SHALL give a first-instruction latency of 2 edges after reset release: edge E0 enters FETCH, edge E1 captures word RESET_PC, and inst_valid is 1 after E1.
REQ-028 SHALL sustain a throughput of one instruction per cycle when mem_gnt=1 and inst_ready=1 continuously.

Reset
REQ-029 SHALL, while rst_n=0 and immediately without a clock edge, set state=IDLE, fpc=RESET_PC, count=0, mem_req=0, inst_valid=0, inst=16'h0000, inst_pc=7'd0.
REQ-030 SHALL discard all buffered instructions when reset is asserted mid-stream; after release the unit behaves exactly as from power-on (REQ-027).

Verification
REQ-031 SHALL pass in-order streaming: memory words 0:F10A, 1:F202, 2:0312; mem_gnt=1 and inst_ready=1 throughout -> inst_valid high after E1, and accepted (inst, inst_pc) sequence is (F10A,0), (F202,1), (0312,2) on consecutive edges.
REQ-032 SHALL pass backpressure: as REQ-031 but inst_ready=0 -> after two pushes count=2, mem_req=0, mem_addr=2, and inst holds F10A; then inst_ready=1 -> F10A, F202, 0312 are delivered in order, with no loss or duplication.
REQ-033 SHALL pass grant stall: mem_gnt=0 for 3 cycles with the FIFO empty -> mem_req=1, mem_addr constant, inst_valid=0; then mem_gnt=1 -> the word at that address appears the next cycle.
REQ-034 SHALL pass redirect with a full buffer: redirect=1, redirect_pc=5 for one cycle with the FIFO full and mem_gnt=1 -> next cycle inst_valid=0 and mem_addr=5; the next delivered instruction is word 5 with inst_pc=5.
REQ-035 SHALL pass wrap-around: redirect to 127 -> delivered inst_pc sequence is 127, 0, 1.
REQ-036 SHALL pass reset mid-stream: rst_n low between edges while count=2 -> inst_valid, mem_req, and inst are all 0 before the next edge; after release the first instruction is word RESET_PC at E1.
